// File: rtl/alu_frame_controller_if.sv
// UART FIFO and ALU signal bundle for alu_frame_controller.
// master = controller side, slave = FIFO/ALU environment side.
interface alu_frame_controller_if #(
    parameter int unsigned DBIT  = 8,
    parameter int unsigned NB_OP = 6,
    parameter int unsigned NB_AB = 8
);
    logic             i_rx_empty;
    logic [DBIT-1:0]  i_r_data;
    logic             o_rd_uart;
    logic             i_tx_full;
    logic             o_wr_uart;
    logic [DBIT-1:0]  o_w_data;
    logic [NB_OP-1:0] o_alu_op;
    logic [NB_AB-1:0] o_alu_a;
    logic [NB_AB-1:0] o_alu_b;
    logic [NB_AB-1:0] i_alu_result;
    logic             o_busy;
    logic             o_frame_err;

    modport master (
        input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        output o_rd_uart, o_wr_uart, o_w_data, o_alu_op, o_alu_a, o_alu_b,
               o_busy, o_frame_err
    );

    modport slave (
        output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        input  o_rd_uart, o_wr_uart, o_w_data, o_alu_op, o_alu_a, o_alu_b,
               o_busy, o_frame_err
    );
endinterface

// File: rtl/alu_frame_controller.sv
// Frame sequencer: SYNC, OP, A, B, CHK from RX FIFO -> ALU -> result/status to TX FIFO.
// Optional inter-byte timeout enabled by defining ALU_FRAME_TIMEOUT_EN.
module alu_frame_controller #(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned NB_OP     = 6,
    parameter int unsigned NB_AB     = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                  clock,
    input  logic                  i_reset,
    alu_frame_controller_if.master bus
);
    localparam logic [DBIT-1:0] STAT_OK   = DBIT'(8'h01);
    localparam logic [DBIT-1:0] STAT_CHK  = DBIT'(8'h02);
    localparam logic [DBIT-1:0] STAT_TMO  = DBIT'(8'h04);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK, S_EXEC, S_SEND_RES, S_SEND_STAT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NB_OP-1:0] r_sh_op, w_sh_op_nxt;
    logic [NB_AB-1:0] r_sh_a, w_sh_a_nxt;
    logic [NB_AB-1:0] r_sh_b, w_sh_b_nxt;
    logic [DBIT-1:0]  r_chk, w_chk_nxt;
    logic [NB_OP-1:0] r_alu_op, w_alu_op_nxt;
    logic [NB_AB-1:0] r_alu_a, w_alu_a_nxt;
    logic [NB_AB-1:0] r_alu_b, w_alu_b_nxt;
    logic [DBIT-1:0]  r_res, w_res_nxt;
    logic [DBIT-1:0]  r_stat, w_stat_nxt;
    logic [DBIT-1:0]  r_w_data, w_w_data_nxt;
    logic             r_busy, r_frame_err, w_frame_err_nxt;
    logic             w_in_get, w_pop, w_push, w_tmo_hit;

    assign w_in_get = (r_state inside {S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK});
    // Reset gating keeps the pop strobe low while the FIFO is held off by reset.
    assign w_pop    = i_reset && !bus.i_rx_empty && (w_in_get || (r_state == S_IDLE));
    assign w_push   = !bus.i_tx_full && (r_state inside {S_SEND_RES, S_SEND_STAT});

`ifdef ALU_FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts consecutive empty cycles inside a frame; hits on the TIMEOUT-th one.
    assign w_tmo_hit = w_in_get && !w_pop && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)                        r_tmo_cnt <= '0;
        else if (w_in_get && !w_pop && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        else                                 r_tmo_cnt <= '0;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_sh_op     <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_chk       <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res       <= '0;
            r_stat      <= '0;
            r_w_data    <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh_op     <= w_sh_op_nxt;
            r_sh_a      <= w_sh_a_nxt;
            r_sh_b      <= w_sh_b_nxt;
            r_chk       <= w_chk_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_res       <= w_res_nxt;
            r_stat      <= w_stat_nxt;
            r_w_data    <= w_w_data_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sh_op_nxt     = r_sh_op;
        w_sh_a_nxt      = r_sh_a;
        w_sh_b_nxt      = r_sh_b;
        w_chk_nxt       = r_chk;
        w_alu_op_nxt    = r_alu_op;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_res_nxt       = r_res;
        w_stat_nxt      = r_stat;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pop && (bus.i_r_data == DBIT'(SYNC_BYTE))) begin
                    w_chk_nxt   = '0;
                    w_state_nxt = S_GET_OP;
                end
            end
            S_GET_OP: begin
                if (w_pop) begin
                    w_sh_op_nxt = bus.i_r_data[NB_OP-1:0];
                    w_chk_nxt   = bus.i_r_data;
                    w_state_nxt = S_GET_A;
                end
            end
            S_GET_A: begin
                if (w_pop) begin
                    w_sh_a_nxt  = bus.i_r_data;
                    w_chk_nxt   = r_chk ^ bus.i_r_data;
                    w_state_nxt = S_GET_B;
                end
            end
            S_GET_B: begin
                if (w_pop) begin
                    w_sh_b_nxt  = bus.i_r_data;
                    w_chk_nxt   = r_chk ^ bus.i_r_data;
                    w_state_nxt = S_GET_CHK;
                end
            end
            S_GET_CHK: begin
                if (w_pop) begin
                    if (bus.i_r_data == r_chk) begin
                        w_alu_op_nxt = r_sh_op;
                        w_alu_a_nxt  = r_sh_a;
                        w_alu_b_nxt  = r_sh_b;
                        w_state_nxt  = S_EXEC;
                    end else begin
                        w_res_nxt       = '0;
                        w_stat_nxt      = STAT_CHK;
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_SEND_RES;
                    end
                end
            end
            S_EXEC: begin
                w_res_nxt   = bus.i_alu_result;
                w_stat_nxt  = STAT_OK;
                w_state_nxt = S_SEND_RES;
            end
            S_SEND_RES: begin
                if (w_push) w_state_nxt = S_SEND_STAT;
            end
            S_SEND_STAT: begin
                if (w_push) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_tmo_hit) begin
            w_res_nxt       = '0;
            w_stat_nxt      = STAT_TMO;
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_SEND_RES;
        end
    end

    // TX byte is registered ahead of the send state so it holds for the whole stall.
    always_comb begin
        w_w_data_nxt = '0;
        case (w_state_nxt)
            S_SEND_RES:  w_w_data_nxt = w_res_nxt;
            S_SEND_STAT: w_w_data_nxt = w_stat_nxt;
            default:     w_w_data_nxt = '0;
        endcase
    end

    assign bus.o_rd_uart   = w_pop;
    assign bus.o_wr_uart   = w_push;
    assign bus.o_w_data    = r_w_data;
    assign bus.o_alu_op    = r_alu_op;
    assign bus.o_alu_a     = r_alu_a;
    assign bus.o_alu_b     = r_alu_b;
    assign bus.o_busy      = r_busy;
    assign bus.o_frame_err = r_frame_err;
endmodule
